// File: rtl/product_accumulator_if.sv
// -----------------------------------------------------------------------------
// product_accumulator_if
//   Bundles the frame-control, input-stream and output-stream signals of
//   product_accumulator.
//
//   master : the side that drives start, product, in_valid and sum_ready
//            (the multiplier and the result consumer, or a bench)
//   slave  : the accumulator itself
//
//   start      frame start pulse (master -> slave)
//   product    unsigned product word, PROD_W bits
//   in_valid   product valid
//   in_ready   accumulator accepts product this cycle
//   sum        accumulated frame sum, ACC_W bits
//   sum_valid  sum holds a completed frame
//   sum_ready  consumer takes sum
//   overflow   frame sum wrapped past 2^ACC_W-1
//   busy       frame in progress or awaiting pickup
//   count      products accepted in the current frame
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface product_accumulator_if #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 10
);
   logic              start;
   logic [PROD_W-1:0] product;
   logic              in_valid;
   logic              in_ready;
   logic [ACC_W-1:0]  sum;
   logic              sum_valid;
   logic              sum_ready;
   logic              overflow;
   logic              busy;
   logic [3:0]        count;

   modport master (
      output start, product, in_valid, sum_ready,
      input  in_ready, sum, sum_valid, overflow, busy, count
   );

   modport slave (
      input  start, product, in_valid, sum_ready,
      output in_ready, sum, sum_valid, overflow, busy, count
   );
endinterface

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//   Sums N_TERMS consecutive unsigned products from the multiplier into an
//   ACC_W-bit accumulator and presents the frame sum with a valid/ready
//   handshake. A sticky flag records any carry out of the accumulator during
//   the frame.
//
//   Ports:
//     clk   rising-edge clock
//     rstn  asynchronous reset, ACTIVE HIGH despite the name; clears all state
//     bus   product_accumulator_if.slave (start, product stream in, sum
//           stream out, overflow, busy, count)
//
//   Parameters:
//     PROD_W   product width
//     ACC_W    accumulator width, must be >= PROD_W
//     N_TERMS  products per frame, 1..15 (count is 4 bits wide)
//
//   Sequencing: IDLE --start--> ACCUM --N_TERMS accepts--> DONE --sum_ready--> IDLE
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module product_accumulator #(
   parameter int PROD_W  = 8,
   parameter int ACC_W   = 10,
   parameter int N_TERMS = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   product_accumulator_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] LAST_COUNT = 4'(N_TERMS);

   state_t            state_q, state_d;
   logic [ACC_W-1:0]  sum_q, sum_d;
   logic [3:0]        count_q, count_d;
   logic              overflow_q, overflow_d;

   // One extra bit on the adder so the carry out is visible for the sticky flag.
   logic [ACC_W:0]    sum_ext;
   logic [3:0]        count_inc;

   always_comb begin
      sum_ext   = {1'b0, sum_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.product};
      count_inc = count_q + 4'd1;

      state_d    = state_q;
      sum_d      = sum_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      case (state_q)
         IDLE: begin
            // sum/overflow/count from the previous frame stay visible until
            // a new frame is started.
            if (bus.start) begin
               state_d    = ACCUM;
               sum_d      = '0;
               count_d    = 4'd0;
               overflow_d = 1'b0;
            end
         end

         ACCUM: begin
            // in_ready is high for the whole of ACCUM, so in_valid alone
            // marks an accepted product.
            if (bus.in_valid) begin
               sum_d      = sum_ext[ACC_W-1:0];
               overflow_d = overflow_q | sum_ext[ACC_W];
               count_d    = count_inc;
               if (count_inc == LAST_COUNT) begin
                  state_d = DONE;
               end
            end
         end

         DONE: begin
            // start is deliberately not looked at here, even on the
            // handshake cycle; a new frame needs a start seen in IDLE.
            if (bus.sum_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_q    <= IDLE;
         sum_q      <= '0;
         count_q    <= 4'd0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sum_q      <= sum_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Handshake and status outputs decode straight from the state register.
   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.sum_valid = (state_q == DONE);
   assign bus.busy      = (state_q == ACCUM) || (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.overflow  = overflow_q;
   assign bus.count     = count_q;

endmodule

// File: tb/tb_product_accumulator.sv
`timescale 1ns/1ps
module tb_product_accumulator;

   logic       clk = 1'b0;
   logic       rstn;
   logic       start;
   logic [7:0] product;
   logic       in_valid;
   logic       sum_ready;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // Default-width instance (ACC_W = 10) and a narrow one (ACC_W = 9) for
   // the overflow case; both see identical stimulus.
   product_accumulator_if #(.PROD_W(8), .ACC_W(10)) a_if ();
   product_accumulator_if #(.PROD_W(8), .ACC_W(9))  n_if ();

   assign a_if.start     = start;
   assign a_if.product   = product;
   assign a_if.in_valid  = in_valid;
   assign a_if.sum_ready = sum_ready;
   assign n_if.start     = start;
   assign n_if.product   = product;
   assign n_if.in_valid  = in_valid;
   assign n_if.sum_ready = sum_ready;

   product_accumulator #(.PROD_W(8), .ACC_W(10), .N_TERMS(4)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (a_if.slave)
   );

   product_accumulator #(.PROD_W(8), .ACC_W(9), .N_TERMS(4)) dut9 (
      .clk  (clk),
      .rstn (rstn),
      .bus  (n_if.slave)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are changed and outputs sampled at negedge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input int p);
      in_valid = 1'b1;
      product  = 8'(p);
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   initial begin
      rstn      = 1'b1;
      start     = 1'b0;
      product   = 8'd0;
      in_valid  = 1'b0;
      sum_ready = 1'b1;
      cyc();
      cyc();

      // ---- reset state ----
      chk("rst_sum",       int'(a_if.sum), 0);
      chk("rst_count",     int'(a_if.count), 0);
      chk("rst_overflow",  int'(a_if.overflow), 0);
      chk("rst_in_ready",  int'(a_if.in_ready), 0);
      chk("rst_sum_valid", int'(a_if.sum_valid), 0);
      chk("rst_busy",      int'(a_if.busy), 0);
      rstn = 1'b0;
      cyc();
      chk("idle_in_ready", int'(a_if.in_ready), 0);

      // ---- basic frame 2,2,4,6 ----
      do_start();
      chk("basic_in_ready", int'(a_if.in_ready), 1);
      chk("basic_busy",     int'(a_if.busy), 1);
      chk("basic_count0",   int'(a_if.count), 0);
      send(2);
      in_valid = 1'b1; product = 8'd2; cyc();
      product = 8'd4; cyc();
      chk("basic_count3",   int'(a_if.count), 3);
      chk("basic_sv_early", int'(a_if.sum_valid), 0);
      product = 8'd6; cyc();
      in_valid = 1'b0;
      chk("basic_sum_valid", int'(a_if.sum_valid), 1);
      chk("basic_sum",       int'(a_if.sum), 14);
      chk("basic_overflow",  int'(a_if.overflow), 0);
      chk("basic_count4",    int'(a_if.count), 4);
      chk("basic_in_ready_done", int'(a_if.in_ready), 0);
      cyc();
      chk("basic_idle_sv",   int'(a_if.sum_valid), 0);
      chk("basic_idle_busy", int'(a_if.busy), 0);
      chk("basic_idle_sum",  int'(a_if.sum), 14);

      // ---- gapped input ----
      do_start();
      chk("gap_sum_cleared", int'(a_if.sum), 0);
      begin
         int prods[4] = '{2, 2, 4, 6};
         for (int i = 0; i < 4; i++) begin
            send(prods[i]);
            if (i < 3) begin
               for (int g = 0; g < 2; g++) begin
                  cyc();
                  chk("gap_count_hold", int'(a_if.count), i + 1);
                  chk("gap_in_ready",   int'(a_if.in_ready), 1);
               end
            end
         end
      end
      chk("gap_sum_valid", int'(a_if.sum_valid), 1);
      chk("gap_sum",       int'(a_if.sum), 14);
      cyc();
      chk("gap_idle", int'(a_if.busy), 0);

      // ---- backpressure ----
      sum_ready = 1'b0;
      do_start();
      for (int i = 0; i < 4; i++) send(1);
      chk("bp_sum_valid", int'(a_if.sum_valid), 1);
      chk("bp_sum",       int'(a_if.sum), 4);
      in_valid = 1'b1;
      product  = 8'd9;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("bp_hold_valid", int'(a_if.sum_valid), 1);
         chk("bp_hold_sum",   int'(a_if.sum), 4);
         chk("bp_hold_count", int'(a_if.count), 4);
         chk("bp_in_ready",   int'(a_if.in_ready), 0);
      end
      sum_ready = 1'b1;
      cyc();
      chk("bp_idle_busy", int'(a_if.busy), 0);
      chk("bp_idle_sum",  int'(a_if.sum), 4);
      cyc();
      chk("bp_idle_ignore", int'(a_if.sum), 4);
      chk("bp_idle_count",  int'(a_if.count), 4);
      in_valid = 1'b0;

      // ---- overflow (ACC_W = 9 instance) ----
      do_start();
      for (int i = 0; i < 4; i++) send(255);
      chk("ovf9_sum",       int'(n_if.sum), 508);
      chk("ovf9_flag",      int'(n_if.overflow), 1);
      chk("ovf9_sum_valid", int'(n_if.sum_valid), 1);
      chk("ovf10_sum",      int'(a_if.sum), 1020);
      chk("ovf10_flag",     int'(a_if.overflow), 0);
      cyc();
      chk("ovf9_flag_idle", int'(n_if.overflow), 1);
      do_start();
      chk("ovf9_flag_clr",  int'(n_if.overflow), 0);
      for (int i = 1; i <= 4; i++) send(i);
      chk("ovf9_next_sum",  int'(n_if.sum), 10);
      chk("ovf9_next_flag", int'(n_if.overflow), 0);
      cyc();

      // ---- asynchronous reset mid-frame ----
      do_start();
      send(4);
      send(5);
      chk("rmid_sum", int'(a_if.sum), 9);
      #2 rstn = 1'b1;
      #1;
      chk("rmid_sum0",      int'(a_if.sum), 0);
      chk("rmid_count0",    int'(a_if.count), 0);
      chk("rmid_busy0",     int'(a_if.busy), 0);
      chk("rmid_in_ready0", int'(a_if.in_ready), 0);
      chk("rmid_sv0",       int'(a_if.sum_valid), 0);
      chk("rmid_ovf0",      int'(a_if.overflow), 0);
      @(negedge clk);
      rstn = 1'b0;
      cyc();
      do_start();
      for (int i = 0; i < 4; i++) send(3);
      chk("rmid_after_sum", int'(a_if.sum), 12);
      cyc();

      // ---- start ignored in ACCUM and at DONE handshake ----
      do_start();
      start = 1'b1;
      send(5);
      send(6);
      chk("sig_count", int'(a_if.count), 2);
      chk("sig_sum",   int'(a_if.sum), 11);
      start = 1'b0;
      send(7);
      send(8);
      chk("sig_done_sum", int'(a_if.sum), 26);
      chk("sig_done_sv",  int'(a_if.sum_valid), 1);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("sig_idle_busy", int'(a_if.busy), 0);
      chk("sig_idle_sum",  int'(a_if.sum), 26);
      cyc();
      chk("sig_still_idle", int'(a_if.in_ready), 0);
      chk("sig_still_sum",  int'(a_if.sum), 26);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
